avst_packetizer: RTL and testbench
==================================

Name: avst_packetizer

Overview:
- Downstream neighbour of the Avalon-ST FIFO. Consumes the FIFO read side: data words, valid = !empty, ready latency 0.
- Frames that unstructured word stream into Avalon-ST packets with startofpacket, endofpacket and empty, using a per-packet length loaded from a small control interface.
- Output is fully registered through a 2-entry skid buffer, so timing is isolated from the downstream sink.

Parameters:
- DATABITS_PER_SYMBOL, 8, bits per symbol
- SYMBOLS_PER_BEAT, 4, symbols per word
- WIDTH, SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL, word width
- LEN_BITS, 16, width of the packet-length field in words
- EMPTY_BITS, $clog2(SYMBOLS_PER_BEAT) (minimum 1), width of the empty field
- CNT_BITS, 16, width of the completed-packet counter

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  request to start a packet; sampled only when cfg_ready=1
- cfg_len  in  LEN_BITS  packet length in words; must be nonzero
- cfg_empty  in  EMPTY_BITS  empty symbols in the last word
- cfg_ready  out  1  high when a new packet length can be loaded
- cfg_err  out  1  one-cycle pulse when cfg_start is sampled with cfg_len==0
- snk_data  in  WIDTH  word from the FIFO read side
- snk_valid  in  1  FIFO not empty
- snk_ready  out  1  word accepted this cycle when snk_valid & snk_ready
- src_data  out  WIDTH  packet data
- src_valid  out  1  output beat valid
- src_ready  in  1  downstream ready, ready latency 0
- src_startofpacket  out  1  first beat of a packet
- src_endofpacket  out  1  last beat of a packet
- src_empty  out  EMPTY_BITS  empty symbols; nonzero only on an eop beat
- busy  out  1  packet in progress, or skid buffer not empty
- pkt_cnt  out  CNT_BITS  count of eop beats delivered on src; wraps

Behaviour:
- Reset (async assert, synchronous deassert sampled on clk):
  - state=IDLE; word_cnt=0; len_q=0; empty_q=0; pkt_cnt=0.
  - Skid buffer empty; src_valid=0; src_data, src_sop, src_eop and src_empty all 0.
  - cfg_err=0; snk_ready=0.
- Reset mid-packet drops all buffered beats. No partial packet is emitted after reset.
- FSM states: IDLE, ACTIVE.
- IDLE:
  - cfg_ready=1, snk_ready=0.
  - cfg_start & cfg_len!=0: latch len_q=cfg_len and empty_q=cfg_empty, set word_cnt=0, go to ACTIVE.
  - cfg_start & cfg_len==0: cfg_err=1 next cycle, stay in IDLE.
- ACTIVE:
  - snk_ready = skid buffer has a free entry. Never depends combinationally on snk_valid.
  - Accept = snk_valid & snk_ready. On accept, push a beat into the skid buffer with:
    - sop = (word_cnt==0)
    - eop = (word_cnt==len_q-1)
    - empty = eop ? empty_q : 0
  - word_cnt increments on each accept.
- On the eop accept:
  - cfg_ready=1 in ACTIVE only on the cycle where an eop accept happens.
  - If cfg_start & cfg_len!=0 in the same cycle: reload len_q and empty_q, set word_cnt=0, stay in ACTIVE. Back-to-back packets have zero bubble.
  - Otherwise go to IDLE.
  - If cfg_start & cfg_len==0 in that cycle: pulse cfg_err and go to IDLE.
- len_q=1: a single beat carries both sop=1 and eop=1.
- cfg_len and cfg_empty are ignored while in ACTIVE except on the eop cycle.
- Skid buffer:
  - Latency is 1 cycle from snk accept to src_valid (buffer empty, src_ready=1).
  - Throughput is 1 beat per cycle under continuous src_ready.
  - src_ready low: holds up to 2 beats. src_data, src_sop, src_eop and src_empty stay stable while src_valid & !src_ready.
  - Push and pop in the same cycle are allowed at any occupancy.
- pkt_cnt increments on src_valid & src_ready & src_endofpacket; wraps 2^CNT_BITS-1 -> 0.
- busy = (state==ACTIVE) | skid buffer non-empty.
- Word-count arithmetic is unsigned LEN_BITS. len_q = 2^LEN_BITS-1 is legal and word_cnt does not overflow.

Decomposition:
- Package avst_pkg: state enum (IDLE, ACTIVE); typedef beat_t, a packed struct {data, sop, eop, empty}; the EMPTY_BITS computation function.
- Sub-module avst_skid_buf: a 2-entry registered valid/ready buffer carrying beat_t, with its own clk and rst. It is reusable on the FIFO write side later.

Test Plan:
- Basic: load len=4, empty=0; FIFO supplies words 0xA0..0xA3; src_ready=1 -> 4 beats, sop on 0xA0, eop on 0xA3, src_empty=0, first src_valid one cycle after first accept, pkt_cnt=1.
- Single-word packet: len=1, empty=3, word 0x11 -> one beat with sop=1, eop=1, empty=3; busy drops to 0 two cycles later.
- Back-to-back: len=3 then len=2 with cfg_start held on the eop-accept cycle; continuous snk_valid -> 5 consecutive src beats with no gap, sop on beats 0 and 3, eop on beats 2 and 4, pkt_cnt=2.
- Backpressure: len=6, src_ready toggles 1,0,0,1,0,1...; snk_valid always 1 -> no beat lost or duplicated, outputs stable while stalled, snk_ready=0 when the buffer holds 2 beats.
- Config error: cfg_start with len=0 in IDLE -> cfg_err pulses for 1 cycle, snk_ready stays 0, no src_valid.
- Reset mid-packet: len=8, assert rst after 3 accepted words -> src_valid=0 immediately, pkt_cnt=0, state IDLE; a new len=2 packet afterwards starts with sop.

Source files
------------

// File: rtl/avst_pkg.sv
// Shared types for the Avalon-ST packetizer: FSM states, the beat record carried
// through the skid buffer, and the empty-field width helper.
package avst_pkg;

    localparam int DEF_DATABITS_PER_SYMBOL = 8;
    localparam int DEF_SYMBOLS_PER_BEAT    = 4;
    localparam int DEF_WIDTH               = DEF_SYMBOLS_PER_BEAT * DEF_DATABITS_PER_SYMBOL;

    // A one-symbol beat still needs a 1-bit empty field.
    function automatic int calc_empty_bits(input int symbols);
        return (symbols > 1) ? $clog2(symbols) : 1;
    endfunction

    localparam int DEF_EMPTY_BITS = calc_empty_bits(DEF_SYMBOLS_PER_BEAT);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]      data;
        logic                      sop;
        logic                      eop;
        logic [DEF_EMPTY_BITS-1:0] empty;
    } beat_t;

endpackage

// File: rtl/avst_skid_buf.sv
// Two-entry registered valid/ready buffer. in_ready comes only from the occupancy
// register, so neither side sees a combinational path through to the other.
module avst_skid_buf #(
    parameter type beat_type = avst_pkg::beat_t
) (
    input  logic     clk,
    input  logic     rst,
    input  beat_type in_beat,
    input  logic     in_valid,
    output logic     in_ready,
    output beat_type out_beat,
    output logic     out_valid,
    input  logic     out_ready
);

    logic [1:0] count;
    beat_type   head;
    beat_type   tail;
    logic       push;
    logic       pop;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_beat  = head;

    // head is always the presented beat; tail only fills while head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (pop) begin
                if (count == 2'd2)
                    head <= tail;
                else if (push)
                    head <= in_beat;
            end else if (push) begin
                if (count == 2'd0)
                    head <= in_beat;
                else
                    tail <= in_beat;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/avst_packetizer.sv
// Frames the FIFO read-side word stream into Avalon-ST packets whose length is
// loaded per packet through the cfg interface; output goes through a skid buffer.
module avst_packetizer
    import avst_pkg::*;
#(
    parameter int DATABITS_PER_SYMBOL = DEF_DATABITS_PER_SYMBOL,
    parameter int SYMBOLS_PER_BEAT    = DEF_SYMBOLS_PER_BEAT,
    parameter int WIDTH               = SYMBOLS_PER_BEAT * DATABITS_PER_SYMBOL,
    parameter int LEN_BITS            = 16,
    parameter int EMPTY_BITS          = calc_empty_bits(SYMBOLS_PER_BEAT),
    parameter int CNT_BITS            = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [LEN_BITS-1:0]   cfg_len,
    input  logic [EMPTY_BITS-1:0] cfg_empty,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    input  logic [WIDTH-1:0]      snk_data,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    output logic [WIDTH-1:0]      src_data,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic                  src_startofpacket,
    output logic                  src_endofpacket,
    output logic [EMPTY_BITS-1:0] src_empty,
    output logic                  busy,
    output logic [CNT_BITS-1:0]   pkt_cnt
);

    localparam logic [LEN_BITS-1:0] LEN_ONE = 1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = 1;

    state_t                state;
    logic [LEN_BITS-1:0]   word_cnt;
    logic [LEN_BITS-1:0]   len_q;
    logic [EMPTY_BITS-1:0] empty_q;
    beat_t                 push_beat;
    beat_t                 pop_beat;
    logic                  buf_ready;
    logic                  accept;
    logic                  is_last;
    logic                  cfg_take;
    logic                  cfg_len_zero;

    assign is_last      = (word_cnt == (len_q - LEN_ONE));
    assign snk_ready    = (state == ACTIVE) && buf_ready;
    assign accept       = snk_valid && snk_ready;
    assign cfg_ready    = (state == IDLE) || (accept && is_last);
    assign cfg_take     = cfg_start && cfg_ready;
    assign cfg_len_zero = (cfg_len == '0);

    always_comb begin
        push_beat       = '0;
        push_beat.data  = snk_data;
        push_beat.sop   = (word_cnt == '0);
        push_beat.eop   = is_last;
        push_beat.empty = is_last ? empty_q : '0;
    end

    // Reload on the eop accept keeps back-to-back packets bubble-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            len_q    <= '0;
            empty_q  <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_take && cfg_len_zero;
            case (state)
                IDLE: begin
                    if (cfg_take && !cfg_len_zero) begin
                        len_q    <= cfg_len;
                        empty_q  <= cfg_empty;
                        word_cnt <= '0;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        if (is_last) begin
                            if (cfg_take && !cfg_len_zero) begin
                                len_q    <= cfg_len;
                                empty_q  <= cfg_empty;
                                word_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            word_cnt <= word_cnt + LEN_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pkt_cnt <= '0;
        else if (src_valid && src_ready && src_endofpacket)
            pkt_cnt <= pkt_cnt + CNT_ONE;
    end

    avst_skid_buf #(
        .beat_type (beat_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_beat   (push_beat),
        .in_valid  (accept),
        .in_ready  (buf_ready),
        .out_beat  (pop_beat),
        .out_valid (src_valid),
        .out_ready (src_ready)
    );

    assign src_data          = pop_beat.data;
    assign src_startofpacket = pop_beat.sop;
    assign src_endofpacket   = pop_beat.eop;
    assign src_empty         = pop_beat.empty;
    assign busy              = (state == ACTIVE) || src_valid;

endmodule

// File: tb/tb_avst_packetizer.sv
// Directed bench for avst_packetizer: per-cycle vector table for the basic,
// single-word, config-error and back-to-back cases, then backpressure and reset.
module tb_avst_packetizer;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic [15:0] cfg_len;
    logic [1:0]  cfg_empty;
    logic        cfg_ready;
    logic        cfg_err;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        src_startofpacket;
    logic        src_endofpacket;
    logic [1:0]  src_empty;
    logic        busy;
    logic [15:0] pkt_cnt;

    int checks = 0;
    int errors = 0;

    avst_packetizer dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_start         (cfg_start),
        .cfg_len           (cfg_len),
        .cfg_empty         (cfg_empty),
        .cfg_ready         (cfg_ready),
        .cfg_err           (cfg_err),
        .snk_data          (snk_data),
        .snk_valid         (snk_valid),
        .snk_ready         (snk_ready),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_startofpacket (src_startofpacket),
        .src_endofpacket   (src_endofpacket),
        .src_empty         (src_empty),
        .busy              (busy),
        .pkt_cnt           (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the test");
        $fatal(1);
    end

    typedef struct {
        logic        cfg_start;
        logic [15:0] cfg_len;
        logic [1:0]  cfg_empty;
        logic        snk_valid;
        logic [31:0] snk_data;
        logic        src_ready;
        logic        e_cfg_ready;
        logic        e_cfg_err;
        logic        e_snk_ready;
        logic        e_src_valid;
        logic [31:0] e_data;
        logic        e_sop;
        logic        e_eop;
        logic [1:0]  e_empty;
        logic        e_busy;
        logic [15:0] e_pkt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic st, input logic [15:0] len, input logic [1:0] emp,
        input logic sv, input logic [31:0] sd, input logic sr,
        input logic ecr, input logic eer, input logic esr, input logic evl,
        input logic [31:0] ed, input logic esop, input logic eeop,
        input logic [1:0] eemp, input logic ebusy, input logic [15:0] epkt);
        vec_t v;
        v.cfg_start = st;   v.cfg_len = len;     v.cfg_empty = emp;
        v.snk_valid = sv;   v.snk_data = sd;     v.src_ready = sr;
        v.e_cfg_ready = ecr; v.e_cfg_err = eer;  v.e_snk_ready = esr;
        v.e_src_valid = evl; v.e_data = ed;      v.e_sop = esop;
        v.e_eop = eeop;     v.e_empty = eemp;    v.e_busy = ebusy;
        v.e_pkt = epkt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        cfg_start = v.cfg_start;
        cfg_len   = v.cfg_len;
        cfg_empty = v.cfg_empty;
        snk_valid = v.snk_valid;
        snk_data  = v.snk_data;
        src_ready = v.src_ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkVector(input int i, input vec_t v);
        string p;
        p = $sformatf("v%0d ", i);
        checkOutput({p, "cfg_ready"}, 32'(cfg_ready), 32'(v.e_cfg_ready));
        checkOutput({p, "cfg_err"},   32'(cfg_err),   32'(v.e_cfg_err));
        checkOutput({p, "snk_ready"}, 32'(snk_ready), 32'(v.e_snk_ready));
        checkOutput({p, "src_valid"}, 32'(src_valid), 32'(v.e_src_valid));
        checkOutput({p, "busy"},      32'(busy),      32'(v.e_busy));
        checkOutput({p, "pkt_cnt"},   32'(pkt_cnt),   32'(v.e_pkt));
        if (v.e_src_valid) begin
            checkOutput({p, "src_data"},  src_data,                 v.e_data);
            checkOutput({p, "src_sop"},   32'(src_startofpacket),   32'(v.e_sop));
            checkOutput({p, "src_eop"},   32'(src_endofpacket),     32'(v.e_eop));
            checkOutput({p, "src_empty"}, 32'(src_empty),           32'(v.e_empty));
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pat [6];
        int   m_cnt;
        int   m_acc;
        int   m_pop;
        logic exp_ready;
        logic do_pop;
        int   cyc;

        // in: start len emp valid data rdy | exp: cfg_rdy err snk_rdy src_vld data sop eop emp busy pkt
        vecs.push_back(mk(1, 4, 0, 0, 32'h0,  1,  1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hA0, 1,  0, 0, 1, 0, 32'h0,  0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hA1, 1,  0, 0, 1, 1, 32'hA0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hA2, 1,  0, 0, 1, 1, 32'hA1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hA3, 1,  1, 0, 1, 1, 32'hA2, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,  1,  1, 0, 0, 1, 32'hA3, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,  1,  1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 3, 0, 32'h0,  1,  1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h11, 1,  1, 0, 1, 0, 32'h0,  0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,  1,  1, 0, 0, 1, 32'h11, 1, 1, 3, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,  1,  1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,  1,  1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'h55, 1,  1, 1, 0, 0, 32'h0,  0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,  1,  1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 3, 0, 0, 32'h0,  1,  1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB0, 1,  0, 0, 1, 0, 32'h0,  0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB1, 1,  0, 0, 1, 1, 32'hB0, 1, 0, 0, 1, 2));
        vecs.push_back(mk(1, 2, 2, 1, 32'hB2, 1,  1, 0, 1, 1, 32'hB1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB3, 1,  0, 0, 1, 1, 32'hB2, 0, 1, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB4, 1,  1, 0, 1, 1, 32'hB3, 1, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,  1,  1, 0, 0, 1, 32'hB4, 0, 1, 2, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,  1,  1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 4));

        rst = 1'b1;
        cfg_start = 1'b0; cfg_len = '0; cfg_empty = '0;
        snk_valid = 1'b0; snk_data = '0; src_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset src_valid", 32'(src_valid), 32'd0);
        checkOutput("reset src_data",  src_data,       32'd0);
        checkOutput("reset src_sop",   32'(src_startofpacket), 32'd0);
        checkOutput("reset src_eop",   32'(src_endofpacket),   32'd0);
        checkOutput("reset src_empty", 32'(src_empty), 32'd0);
        checkOutput("reset cfg_err",   32'(cfg_err),   32'd0);
        checkOutput("reset snk_ready", 32'(snk_ready), 32'd0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("reset busy",      32'(busy),      32'd0);
        checkOutput("reset pkt_cnt",   32'(pkt_cnt),   32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #2;
            checkVector(i, vecs[i]);
            nextCycle();
        end

        // Backpressure: len=6, empty=1, src_ready cycling 1,0,0,1,0,1.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cfg_start = 1'b1; cfg_len = 16'd6; cfg_empty = 2'd1;
        snk_valid = 1'b0; src_ready = 1'b1;
        nextCycle();
        cfg_start = 1'b0;
        m_cnt = 0; m_acc = 0; m_pop = 0;
        cyc = 0;
        while (cyc < 60 && m_pop < 6) begin
            src_ready = pat[cyc % 6];
            snk_valid = 1'b1;
            snk_data  = 32'hC0 + 32'(m_acc);
            #2;
            exp_ready = (m_acc < 6) && (m_cnt < 2);
            checkOutput("bp snk_ready", 32'(snk_ready), 32'(exp_ready));
            checkOutput("bp src_valid", 32'(src_valid), 32'(m_cnt > 0));
            if (m_cnt > 0) begin
                checkOutput("bp src_data",  src_data, 32'hC0 + 32'(m_pop));
                checkOutput("bp src_sop",   32'(src_startofpacket), 32'(m_pop == 0));
                checkOutput("bp src_eop",   32'(src_endofpacket),   32'(m_pop == 5));
                checkOutput("bp src_empty", 32'(src_empty), (m_pop == 5) ? 32'd1 : 32'd0);
            end
            do_pop = (m_cnt > 0) && pat[cyc % 6];
            nextCycle();
            m_cnt = m_cnt + (exp_ready ? 1 : 0) - (do_pop ? 1 : 0);
            m_acc = m_acc + (exp_ready ? 1 : 0);
            m_pop = m_pop + (do_pop ? 1 : 0);
            cyc++;
        end
        if (m_pop < 6) begin
            errors++;
            $display("[TB] FAIL bp timeout: delivered %0d beats, expected 6", m_pop);
        end
        snk_valid = 1'b0;
        src_ready = 1'b1;
        #2;
        checkOutput("bp pkt_cnt", 32'(pkt_cnt), 32'd5);
        checkOutput("bp busy",    32'(busy),    32'd0);
        nextCycle();

        // Reset in the middle of a len=8 packet after three accepted words.
        cfg_start = 1'b1; cfg_len = 16'd8; cfg_empty = 2'd0;
        nextCycle();
        cfg_start = 1'b0;
        snk_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            snk_data = 32'hD0 + 32'(k);
            nextCycle();
        end
        snk_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst src_valid", 32'(src_valid), 32'd0);
        checkOutput("rst pkt_cnt",   32'(pkt_cnt),   32'd0);
        checkOutput("rst busy",      32'(busy),      32'd0);
        checkOutput("rst cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst snk_ready", 32'(snk_ready), 32'd0);
        nextCycle();
        rst = 1'b0;
        cfg_start = 1'b1; cfg_len = 16'd2; cfg_empty = 2'd0;
        nextCycle();
        cfg_start = 1'b0;
        snk_valid = 1'b1;
        snk_data  = 32'hE0;
        nextCycle();
        snk_data = 32'hE1;
        #2;
        checkOutput("post-rst beat0 valid", 32'(src_valid), 32'd1);
        checkOutput("post-rst beat0 data",  src_data,       32'hE0);
        checkOutput("post-rst beat0 sop",   32'(src_startofpacket), 32'd1);
        checkOutput("post-rst beat0 eop",   32'(src_endofpacket),   32'd0);
        nextCycle();
        snk_valid = 1'b0;
        #2;
        checkOutput("post-rst beat1 data", src_data, 32'hE1);
        checkOutput("post-rst beat1 sop",  32'(src_startofpacket), 32'd0);
        checkOutput("post-rst beat1 eop",  32'(src_endofpacket),   32'd1);
        nextCycle();
        #2;
        checkOutput("post-rst pkt_cnt", 32'(pkt_cnt), 32'd1);
        checkOutput("post-rst busy",    32'(busy),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
